// File: rtl/move_queue.sv
// move_queue: encodes button direction pulses as 2-bit move commands and buffers them for the frog FSM.
// Optional MOVE_QUEUE_FLUSH_EN adds a synchronous flush input that discards all queued moves.
module move_queue #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
`ifdef MOVE_QUEUE_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          up_p,
    input  logic          down_p,
    input  logic          left_p,
    input  logic          right_p,
    input  logic          cmd_ready,
    output logic          cmd_valid,
    output logic [1:0]    cmd_dir,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow,
    output logic          collide
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_collide;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_multi;
    logic [1:0]    w_dir;

`ifdef MOVE_QUEUE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_push  = up_p | down_p | left_p | right_p;
    assign w_dir   = up_p ? 2'b00 : down_p ? 2'b01 : left_p ? 2'b10 : 2'b11;
    assign w_multi = (up_p & (down_p | left_p | right_p)) | (down_p & (left_p | right_p)) | (left_p & right_p);
    assign w_full  = r_count == CW'(DEPTH);
    assign w_pop   = cmd_valid & cmd_ready;
    // a pop in the same cycle frees the slot, so a push into a full queue still lands
    assign w_wr    = w_push & (~w_full | w_pop);

    assign cmd_valid = r_count != '0;
    assign cmd_dir   = r_mem[r_rd];
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign collide   = r_collide;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_collide  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
        end else begin
            r_collide <= w_multi;
            if (w_flush) begin
                r_wr       <= '0;
                r_rd       <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_mem[r_wr] <= w_dir;
                    r_wr        <= r_wr + 1'b1;
                end
                if (w_pop) r_rd <= r_rd + 1'b1;
                if (w_wr && !w_pop) r_count <= r_count + 1'b1;
                else if (w_pop && !w_wr) r_count <= r_count - 1'b1;
                if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_move_queue.sv
// tb_move_queue: scoreboard bench for move_queue; a queue of expected commands is filled as pulses are driven.
module tb_move_queue;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          up_p = 1'b0, down_p = 1'b0, left_p = 1'b0, right_p = 1'b0, cmd_ready = 1'b0;
    logic          cmd_valid, full, overflow, collide;
    logic [1:0]    cmd_dir;
    logic [CW-1:0] count;

    logic [1:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_col = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    move_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
`ifdef MOVE_QUEUE_FLUSH_EN
        .flush(flush),
`endif
        .up_p(up_p),
        .down_p(down_p),
        .left_p(left_p),
        .right_p(right_p),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_dir(cmd_dir),
        .count(count),
        .full(full),
        .overflow(overflow),
        .collide(collide)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // called at a falling edge; checks outputs, advances the model, returns at the next falling edge
    task automatic cyc(input logic u, input logic d, input logic l, input logic r, input logic rdy);
        logic [1:0] dir;
        up_p = u;
        down_p = d;
        left_p = l;
        right_p = r;
        cmd_ready = rdy;
        #1;
        check("valid", int'(cmd_valid), int'(sb.size() != 0));
        check("count", int'(count), sb.size());
        check("full", int'(full), int'(sb.size() == DEPTH));
        check("overflow", int'(overflow), int'(m_ovf));
        check("collide", int'(collide), int'(m_col));
        if (sb.size() != 0) check("dir", int'(cmd_dir), int'(sb[0]));
        dir = u ? 2'b00 : d ? 2'b01 : l ? 2'b10 : 2'b11;
        if (flush) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            if (rdy && sb.size() != 0) void'(sb.pop_front());
            if (u | d | l | r) begin
                if (sb.size() < DEPTH) sb.push_back(dir);
                else m_ovf = 1'b1;
            end
        end
        m_col = (int'(u) + int'(d) + int'(l) + int'(r)) > 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // reset is dropped between edges so the clear must be visible before any clock
    task automatic do_reset();
        up_p = 0; down_p = 0; left_p = 0; right_p = 0; cmd_ready = 0; flush = 0;
        #2 reset = 1'b0;
        #1;
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_col", int'(collide), 0);
        check("rst_dir", int'(cmd_dir), 0);
        sb.delete();
        m_ovf = 1'b0;
        m_col = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);

        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 1);

        do_reset();
        repeat (5) cyc(1, 0, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        repeat (5) cyc(0, 0, 0, 0, 1);

        do_reset();
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);

        do_reset();
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        do_reset();
        repeat (2) cyc(0, 0, 0, 0, 0);

`ifdef MOVE_QUEUE_FLUSH_EN
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        flush = 1'b1;
        cyc(0, 0, 1, 0, 1);
        flush = 1'b0;
        repeat (2) cyc(0, 0, 0, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/move_queue.md
Name: move_queue

Overview:
Consumer end of the button edge-pulse interface. Accepts single-cycle direction pulses from the four per-button edge detectors, encodes each pulse as a 2-bit move command and buffers it in a small FIFO. Hands commands to the frog movement FSM over a valid/ready handshake, so moves issued while the game logic is busy (e.g. mid-animation) are not lost.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
up_p  input  1  one-cycle press pulse, up
down_p  input  1  one-cycle press pulse, down
left_p  input  1  one-cycle press pulse, left
right_p  input  1  one-cycle press pulse, right
cmd_ready  input  1  consumer accepts the head command this cycle
cmd_valid  output  1  head command present
cmd_dir  output  2  head command: 00 up, 01 down, 10 left, 11 right
count  output  CW  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky: a pulse was dropped because the FIFO was full
collide  output  1  one-cycle flag: more than one pulse arrived in the same cycle

Behaviour:
- Reset (reset low, async assert, sync deassert by the system): pointers 0, count 0, cmd_valid 0, cmd_dir 00, full 0, overflow 0, collide 0.
- Push request = OR of the four pulses. Encode with fixed priority: up > down > left > right. Lower-priority simultaneous pulses are discarded, and collide is asserted for that one cycle.
- Pop = cmd_valid & cmd_ready. cmd_dir is driven from the head entry; it is a registered-storage read with no combinational path from pulses to outputs.
- Latency: a pulse in cycle N into an empty FIFO gives cmd_valid=1 with that cmd_dir in cycle N+1. No same-cycle bypass.
- cmd_dir holds stable while cmd_valid=1 and cmd_ready=0.
- Ordering is strict FIFO.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- count: +1 on push-only, -1 on pop-only, unchanged on push and pop together.
- Full, push with no pop: the pulse is dropped and overflow is set. Storage and count are unchanged.
- Full, push and pop together: both occur, and count stays at DEPTH.
- Empty: cmd_ready is ignored. Pop is impossible because cmd_valid=0.
- overflow clears only on reset (or on flush, see Optional Feature).
- Reset mid-operation: all queued commands are discarded immediately and the outputs take their reset values.
- cmd_ready high with cmd_valid low has no effect.

Optional Feature:
MOVE_QUEUE_FLUSH_EN
- Defined: adds input port flush (1 bit, synchronous, active-high). When flush=1, the next edge sets pointers and count to 0 and clears overflow. Any push or pop in the same cycle is ignored, so flush wins. cmd_valid is 0 in the following cycle. Used on frog death or level change so stale moves are discarded.
- Undefined: no flush port. Only reset empties the queue.

Test Plan:
- Reset then single pulse: reset low 3 cycles, release, up_p one cycle, cmd_ready=0 -> next cycle cmd_valid=1, cmd_dir=00, count=1; held for 5 cycles unchanged.
- Ordering: pulses right, left, down on consecutive cycles, cmd_ready=0, then cmd_ready=1 -> cmd_dir sequence 11, 10, 01 on successive cycles; count goes 3, 2, 1, 0; cmd_valid falls after third pop.
- Overflow (DEPTH=4): 5 up_p pulses, cmd_ready=0 -> count=4, full=1, overflow=1; drain yields exactly 4 commands of 00; overflow remains 1 afterwards.
- Full with simultaneous push/pop: fill 4 entries, then pulse left_p with cmd_ready=1 -> count stays 4, overflow stays 0, last entry popped is 10.
- Collision: up_p and right_p in the same cycle -> collide=1 for one cycle, one entry 00 queued, count=1.
- Async reset mid-stream: 3 entries queued, drop reset between clock edges -> cmd_valid, count and full go 0 without waiting for a clock edge. With MOVE_QUEUE_FLUSH_EN: flush=1 with 2 entries and a concurrent pulse -> count=0 and cmd_valid=0 the next cycle.
